// File: rtl/mac_array_seq_ctrl_if.sv
// mac_array_seq_ctrl_if: control, operand-read and array-feed bundle of the MAC array sequencer.
//   start/k_len/accumulate/abort : run request and cancel (driven by master)
//   busy/done                    : run status and completion pulse
//   a_/b_rd_en, a_/b_rd_addr     : operand buffer read strobes and address k
//   a_/b_rd_data                 : 4 lanes of operands, valid one cycle after the read strobe
//   a_in_0..3, b_in_0..3         : skewed array feeds
//   mac_en/mac_clr               : array enable and accumulator clear
interface mac_array_seq_ctrl_if #(
   parameter int DW = 16,
   parameter int KW = 8
);
   logic          start;
   logic [KW-1:0] k_len;
   logic          accumulate;
   logic          abort;
   logic          busy;
   logic          done;
   logic          a_rd_en;
   logic          b_rd_en;
   logic [KW-1:0] a_rd_addr;
   logic [KW-1:0] b_rd_addr;
   logic [4*DW-1:0] a_rd_data;
   logic [4*DW-1:0] b_rd_data;
   logic [DW-1:0] a_in_0, a_in_1, a_in_2, a_in_3;
   logic [DW-1:0] b_in_0, b_in_1, b_in_2, b_in_3;
   logic          mac_en;
   logic          mac_clr;
   modport master (
      output start, k_len, accumulate, abort, a_rd_data, b_rd_data,
      input  busy, done, a_rd_en, b_rd_en, a_rd_addr, b_rd_addr,
      input  a_in_0, a_in_1, a_in_2, a_in_3, b_in_0, b_in_1, b_in_2, b_in_3,
      input  mac_en, mac_clr
   );
   modport slave (
      input  start, k_len, accumulate, abort, a_rd_data, b_rd_data,
      output busy, done, a_rd_en, b_rd_en, a_rd_addr, b_rd_addr,
      output a_in_0, a_in_1, a_in_2, a_in_3, b_in_0, b_in_1, b_in_2, b_in_3,
      output mac_en, mac_clr
   );
endinterface

// File: rtl/mac_array_seq_ctrl.sv
// mac_array_seq_ctrl: sequences one K-deep tile through a 4x4 MAC array (clear, feed, drain, done).
//   clk, rst : clock and asynchronous active-high reset
//   bus      : slave side of mac_array_seq_ctrl_if (run control, operand reads, skewed feeds, array control)
module mac_array_seq_ctrl #(
   parameter int DW = 16,
   parameter int KW = 8,
   parameter int DRAIN_CYC = 12
) (
   input logic clk,
   input logic rst,
   mac_array_seq_ctrl_if.slave bus
);
   localparam int CW = $clog2(DRAIN_CYC);
   typedef enum logic [2:0] {IDLE, CLEAR, FEED, DRAIN, DONE} state_t;
   state_t        state;
   logic [KW-1:0] k_q;
   logic [KW-1:0] addr;
   logic [CW-1:0] cnt;
   logic          busy_q, done_q, rd_en, mac_en_q, mac_clr_q;
   logic          flush;
   logic          rd_d;
   logic [2:0]    v;
   logic [4*DW-1:0] a_feed;
   logic [4*DW-1:0] b_feed;
   assign flush = bus.abort && state != IDLE;
   always_ff @(posedge clk or posedge rst)
      if (rst) begin
         state     <= IDLE;
         k_q       <= '0;
         addr      <= '0;
         cnt       <= '0;
         busy_q    <= 1'b0;
         done_q    <= 1'b0;
         rd_en     <= 1'b0;
         mac_en_q  <= 1'b0;
         mac_clr_q <= 1'b0;
      end else if (flush) begin
         state     <= IDLE;
         addr      <= '0;
         cnt       <= '0;
         busy_q    <= 1'b0;
         done_q    <= 1'b0;
         rd_en     <= 1'b0;
         mac_en_q  <= 1'b0;
         mac_clr_q <= 1'b0;
      end else begin
         case (state)
            IDLE:
               if (bus.start && !bus.abort) begin
                  k_q       <= bus.k_len;
                  busy_q    <= 1'b1;
                  state     <= bus.k_len == '0 ? DONE : CLEAR;
                  done_q    <= bus.k_len == '0;
                  mac_clr_q <= bus.k_len != '0 && !bus.accumulate;
               end
            CLEAR: begin
               state     <= FEED;
               mac_clr_q <= 1'b0;
               mac_en_q  <= 1'b1;
               rd_en     <= 1'b1;
               addr      <= '0;
            end
            FEED:
               if (addr == k_q - 1'b1) begin
                  state <= DRAIN;
                  rd_en <= 1'b0;
                  addr  <= '0;
                  cnt   <= '0;
               end else
                  addr <= addr + 1'b1;
            DRAIN:
               if (cnt == CW'(DRAIN_CYC - 1)) begin
                  state    <= DONE;
                  mac_en_q <= 1'b0;
                  done_q   <= 1'b1;
               end else
                  cnt <= cnt + 1'b1;
            DONE: begin
               state  <= IDLE;
               done_q <= 1'b0;
               busy_q <= 1'b0;
            end
            default: state <= IDLE;
         endcase
      end
   // rd_d marks read data present on a/b_rd_data; v[j] marks skew stage j holding valid data
   always_ff @(posedge clk or posedge rst)
      if (rst) begin
         rd_d <= 1'b0;
         v    <= '0;
      end else if (flush) begin
         rd_d <= 1'b0;
         v    <= '0;
      end else begin
         rd_d <= rd_en;
         v    <= {v[1:0], rd_d};
      end
   // lane r passes through r+1 stages so that row/column r enters the array r cycles later
   for (genvar r = 0; r < 4; r++) begin : g_lane
      logic [DW-1:0] a_sk [r+1];
      logic [DW-1:0] b_sk [r+1];
      always_ff @(posedge clk or posedge rst)
         if (rst) begin
            for (int j = 0; j <= r; j++) begin
               a_sk[j] <= '0;
               b_sk[j] <= '0;
            end
         end else if (flush) begin
            for (int j = 0; j <= r; j++) begin
               a_sk[j] <= '0;
               b_sk[j] <= '0;
            end
         end else begin
            a_sk[0] <= rd_d ? bus.a_rd_data[r*DW +: DW] : '0;
            b_sk[0] <= rd_d ? bus.b_rd_data[r*DW +: DW] : '0;
            for (int j = 1; j <= r; j++) begin
               a_sk[j] <= v[j-1] ? a_sk[j-1] : '0;
               b_sk[j] <= v[j-1] ? b_sk[j-1] : '0;
            end
         end
      assign a_feed[r*DW +: DW] = a_sk[r];
      assign b_feed[r*DW +: DW] = b_sk[r];
   end
   assign bus.busy      = busy_q;
   assign bus.done      = done_q;
   assign bus.a_rd_en   = rd_en;
   assign bus.b_rd_en   = rd_en;
   assign bus.a_rd_addr = addr;
   assign bus.b_rd_addr = addr;
   assign bus.mac_en    = mac_en_q;
   assign bus.mac_clr   = mac_clr_q;
   assign bus.a_in_0    = a_feed[0*DW +: DW];
   assign bus.a_in_1    = a_feed[1*DW +: DW];
   assign bus.a_in_2    = a_feed[2*DW +: DW];
   assign bus.a_in_3    = a_feed[3*DW +: DW];
   assign bus.b_in_0    = b_feed[0*DW +: DW];
   assign bus.b_in_1    = b_feed[1*DW +: DW];
   assign bus.b_in_2    = b_feed[2*DW +: DW];
   assign bus.b_in_3    = b_feed[3*DW +: DW];
endmodule

// File: tb/tb_mac_array_seq_ctrl.sv
// tb_mac_array_seq_ctrl: directed bench for mac_array_seq_ctrl with operand buffers and a 4x4 systolic array model.
module tb_mac_array_seq_ctrl;
   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;
   mac_array_seq_ctrl_if #(.DW(16), .KW(8)) bus ();
   mac_array_seq_ctrl #(.DW(16), .KW(8), .DRAIN_CYC(12)) dut (
      .clk(clk),
      .rst(rst),
      .bus(bus.slave)
   );
   int checks = 0;
   int errors = 0;
   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got %0d expected %0d", tag, got, exp);
      end
   endtask
   int a_m [4][4] = '{'{1, 2, 3, 4}, '{5, 6, 7, 8}, '{9, 10, 11, 12}, '{13, 14, 15, 16}};
   int b_m [4][4] = '{'{2, 0, 1, 0}, '{0, 2, 0, 1}, '{1, 0, 2, 0}, '{0, 1, 0, 2}};
   // operand buffers: lane r of A is A[r][k], lane c of B is B[k][c], one cycle read latency
   always @(posedge clk)
      if (bus.a_rd_en)
         for (int r = 0; r < 4; r++) bus.a_rd_data[r*16 +: 16] <= 16'(a_m[r][bus.a_rd_addr[1:0]]);
   always @(posedge clk)
      if (bus.b_rd_en)
         for (int c = 0; c < 4; c++) bus.b_rd_data[c*16 +: 16] <= 16'(b_m[bus.b_rd_addr[1:0]][c]);
   logic [15:0] ain [4];
   logic [15:0] bin [4];
   logic        feed_or;
   always_comb begin
      ain[0] = bus.a_in_0; ain[1] = bus.a_in_1; ain[2] = bus.a_in_2; ain[3] = bus.a_in_3;
      bin[0] = bus.b_in_0; bin[1] = bus.b_in_1; bin[2] = bus.b_in_2; bin[3] = bus.b_in_3;
   end
   assign feed_or = |{bus.a_in_0, bus.a_in_1, bus.a_in_2, bus.a_in_3,
                      bus.b_in_0, bus.b_in_1, bus.b_in_2, bus.b_in_3};
   // output-stationary array: A moves right, B moves down, each PE accumulates its products
   logic [31:0] pa [4][4];
   logic [31:0] pb [4][4];
   logic [31:0] cm [4][4];
   always @(posedge clk or posedge rst)
      if (rst || bus.mac_clr) begin
         for (int r = 0; r < 4; r++)
            for (int c = 0; c < 4; c++) begin
               pa[r][c] <= 0; pb[r][c] <= 0; cm[r][c] <= 0;
            end
      end else if (bus.mac_en) begin
         for (int r = 0; r < 4; r++)
            for (int c = 0; c < 4; c++) cm[r][c] <= cm[r][c] + pa[r][c] * pb[r][c];
         for (int r = 0; r < 4; r++) begin
            pa[r][0] <= 32'(ain[r]);
            for (int c = 1; c < 4; c++) pa[r][c] <= pa[r][c-1];
         end
         for (int c = 0; c < 4; c++) begin
            pb[0][c] <= 32'(bin[c]);
            for (int r = 1; r < 4; r++) pb[r][c] <= pb[r-1][c];
         end
      end
   int first_done, n_done, n_rd, a3_first, max_addr;
   bit rd_seen, mac_en_seen, mac_clr_seen, snap_busy, snap_mac, snap_feed;
   logic [7:0] addr_log [4];
   task automatic launch(input logic [7:0] k, input logic acc);
      @(negedge clk);
      bus.k_len = k;
      bus.accumulate = acc;
      bus.start = 1'b1;
      @(posedge clk);
      #1 bus.start = 1'b0;
   endtask
   // cycle c is the c-th cycle after the accepting edge; start/abort set at cycle c act on its closing edge
   task automatic watch(input int n, input int start_at, input int abort_at, input int snap_at);
      first_done = -1; n_done = 0; n_rd = 0; a3_first = -1; max_addr = 0;
      rd_seen = 0; mac_en_seen = 0; mac_clr_seen = 0;
      for (int i = 0; i < 4; i++) addr_log[i] = 8'hff;
      for (int c = 1; c <= n; c++) begin
         @(negedge clk);
         if (bus.done) begin
            n_done++;
            if (first_done < 0) first_done = c;
         end
         if (bus.a_rd_en) begin
            rd_seen = 1;
            if (n_rd < 4) addr_log[n_rd] = bus.a_rd_addr;
            if (int'(bus.a_rd_addr) > max_addr) max_addr = int'(bus.a_rd_addr);
            n_rd++;
         end
         if (bus.mac_en) mac_en_seen = 1;
         if (bus.mac_clr) mac_clr_seen = 1;
         if (bus.a_in_3 == 16'd13 && a3_first < 0) a3_first = c;
         if (c == snap_at) begin
            snap_busy = bus.busy; snap_mac = bus.mac_en; snap_feed = feed_or;
         end
         bus.start = (c == start_at);
         bus.abort = (c == abort_at);
      end
      bus.start = 1'b0;
      bus.abort = 1'b0;
   endtask
   initial begin
      bus.start = 1'b0; bus.k_len = '0; bus.accumulate = 1'b0; bus.abort = 1'b0;
      #12;
      check("rst_busy", bus.busy, 0);
      check("rst_outs", {bus.done, bus.a_rd_en, bus.b_rd_en, bus.mac_en, bus.mac_clr, feed_or}, 0);
      @(negedge clk) rst = 1'b0;
      @(negedge clk);
      check("idle_busy", bus.busy, 0);
      launch(8'd4, 1'b0);
      watch(22, 0, 0, 0);
      check("t1_addrs", {addr_log[0], addr_log[1], addr_log[2], addr_log[3]}, 32'h00010203);
      check("t1_nrd", n_rd, 4);
      check("t1_a3_13_cycle", a3_first, 7);
      check("t1_done_cycle", first_done, 18);
      check("t1_ndone", n_done, 1);
      check("t1_clr", mac_clr_seen, 1);
      check("t1_c00", cm[0][0], 5);
      check("t1_c11", cm[1][1], 20);
      check("t1_c22", cm[2][2], 31);
      check("t1_c33", cm[3][3], 46);
      check("t1_c03", cm[0][3], 10);
      check("t1_c30", cm[3][0], 41);
      launch(8'd4, 1'b1);
      watch(22, 0, 0, 0);
      check("acc_clr", mac_clr_seen, 0);
      check("acc_done_cycle", first_done, 18);
      check("acc_c00", cm[0][0], 10);
      check("acc_c11", cm[1][1], 40);
      check("acc_c22", cm[2][2], 62);
      check("acc_c33", cm[3][3], 92);
      launch(8'd0, 1'b0);
      watch(5, 0, 0, 0);
      check("k0_done_cycle", first_done, 1);
      check("k0_ndone", n_done, 1);
      check("k0_rd", rd_seen, 0);
      check("k0_mac_en", mac_en_seen, 0);
      launch(8'd4, 1'b0);
      bus.k_len = 8'd9;
      watch(25, 3, 0, 0);
      check("cont_ndone", n_done, 1);
      check("cont_done_cycle", first_done, 18);
      check("cont_nrd", n_rd, 4);
      check("cont_c00", cm[0][0], 5);
      launch(8'd4, 1'b0);
      watch(20, 0, 3, 4);
      check("abort_busy", snap_busy, 0);
      check("abort_mac_en", snap_mac, 0);
      check("abort_feeds", snap_feed, 0);
      check("abort_ndone", n_done, 0);
      launch(8'd4, 1'b0);
      watch(8, 0, 0, 0);
      check("drain_feeds_live", feed_or, 1);
      #2 rst = 1'b1;
      #1;
      check("arst_busy", bus.busy, 0);
      check("arst_outs", {bus.done, bus.a_rd_en, bus.mac_en, bus.mac_clr, feed_or}, 0);
      check("arst_addr", bus.a_rd_addr, 0);
      @(negedge clk) rst = 1'b0;
      watch(20, 0, 0, 0);
      check("arst_ndone", n_done, 0);
      launch(8'd4, 1'b0);
      watch(22, 0, 0, 0);
      check("fresh_done_cycle", first_done, 18);
      check("fresh_c00", cm[0][0], 5);
      check("fresh_c33", cm[3][3], 46);
      launch(8'd255, 1'b0);
      watch(275, 0, 0, 0);
      check("kmax_nrd", n_rd, 255);
      check("kmax_max_addr", max_addr, 254);
      check("kmax_done_cycle", first_done, 269);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
